rep3_serial_tx: RTL and testbench

Triple-repetition serial transmitter. It is the encoding end of the team's repetition-coded bit link, and the receiving end recovers each bit by 3-input majority vote.
- Accepts one parallel word per frame over a valid/ready handshake.
- Serialises the word as a start bit followed by data MSB-first.
- Emits every bit as REPEAT identical consecutive chips on a valid/ready chip stream.
- Sits between the control/data path and the serial link driver.

---
 rtl/rep_code_pkg.sv | 18 +
 rtl/rep3_serial_tx_counter.sv | 35 +++
 rtl/rep3_serial_tx.sv | 143 ++++++++++++++
 tb/tb_rep3_serial_tx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rep_code_pkg.sv
// Shared definitions for the repetition-coded bit link: FSM states, start bit
// value and frame sizing used by both transmitter and receiver.
package rep_code_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam logic START_BIT      = 1'b1;
  localparam int   DEFAULT_REPEAT = 3;

  // Chips on the wire for one frame: start bit plus data, each repeated.
  function automatic int chips_per_frame(input int data_w, input int rep);
    return rep * (data_w + 1);
  endfunction

endpackage

// File: rtl/rep3_serial_tx_counter.sv
// Modulo-N counter with synchronous clear and enable; wrap flags the enabled
// cycle in which the count returns from N-1 to 0.
module mod_n_counter #(
  parameter  int N = 3,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count_q, count_d;

  assign wrap  = en && (count_q == LAST);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = wrap ? '0 : count_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator runs the blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/rep3_serial_tx.sv
// Triple-repetition serial transmitter: takes a word, sends a start bit then
// the data MSB-first, each bit as REPEAT identical chips on a valid/ready link.
module rep3_serial_tx
  import rep_code_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REPEAT = DEFAULT_REPEAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_valid,
  output logic              tx_bit,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

  if (REPEAT < 1 || (REPEAT % 2) == 0) begin : g_bad_repeat
    $error("rep3_serial_tx: REPEAT must be odd and >= 1");
  end
  if (DATA_W < 1) begin : g_bad_width
    $error("rep3_serial_tx: DATA_W must be >= 1");
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              in_ready_q, in_ready_d;
  logic              tx_valid_q, tx_valid_d;
  logic              tx_bit_q, tx_bit_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [REP_W-1:0] rep_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             rep_wrap;
  logic             bit_wrap_unused;
  logic             accept, fire, last_chip;

  assign accept    = (state_q == IDLE) && in_valid && in_ready_q;
  assign fire      = tx_valid_q && tx_ready;
  assign last_chip = (bit_cnt == BIT_LAST) && (rep_cnt == REP_LAST);

  mod_n_counter #(.N(REPEAT)) u_rep_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (fire),
    .count (rep_cnt),
    .wrap  (rep_wrap)
  );

  // Frame end is decoded from both counts; the bit counter's own wrap would
  // duplicate that decode.
  mod_n_counter #(.N(DATA_W + 1)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (rep_wrap),
    .count (bit_cnt),
    .wrap  (bit_wrap_unused)
  );

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    in_ready_d = in_ready_q;
    tx_valid_d = tx_valid_q;
    tx_bit_d   = tx_bit_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        tx_valid_d = 1'b0;
        tx_bit_d   = 1'b0;
        busy_d     = 1'b0;
        if (accept) begin
          state_d    = SEND;
          shreg_d    = in_data;
          in_ready_d = 1'b0;
          tx_valid_d = 1'b1;
          tx_bit_d   = START_BIT;
          busy_d     = 1'b1;
        end
      end
      SEND: begin
        if (fire) begin
          if (last_chip) begin
            state_d    = IDLE;
            in_ready_d = 1'b1;
            tx_valid_d = 1'b0;
            tx_bit_d   = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else if (rep_wrap) begin
            // The start bit has no shift-register slot, so the word's MSB is
            // always the next bit to go out when a bit's repeats finish.
            tx_bit_d = shreg_q[DATA_W-1];
            shreg_d  = shreg_q << 1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      in_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_bit_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      in_ready_q <= in_ready_d;
      tx_valid_q <= tx_valid_d;
      tx_bit_q   <= tx_bit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign tx_valid = tx_valid_q;
  assign tx_bit   = tx_bit_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rep3_serial_tx.sv
// Bench for rep3_serial_tx: directed frames, stall, busy input, mid-frame
// reset, a DATA_W=4/REPEAT=1 instance, and a randomised majority-vote loopback.
module tb_rep3_serial_tx;
  import rep_code_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       tx_valid;
  logic       tx_bit;
  logic       tx_ready;
  logic       busy;
  logic       done;

  logic       c_in_valid;
  logic [3:0] c_in_data;
  logic       c_in_ready;
  logic       c_tx_valid;
  logic       c_tx_bit;
  logic       c_tx_ready;
  logic       c_busy;
  logic       c_done;

  int total = 0;
  int bad   = 0;

  rep3_serial_tx #(.DATA_W(8), .REPEAT(3)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .tx_valid (tx_valid),
    .tx_bit   (tx_bit),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  rep3_serial_tx #(.DATA_W(4), .REPEAT(1)) u_dut_c (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (c_in_valid),
    .in_data  (c_in_data),
    .in_ready (c_in_ready),
    .tx_valid (c_tx_valid),
    .tx_bit   (c_tx_bit),
    .tx_ready (c_tx_ready),
    .busy     (c_busy),
    .done     (c_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference chip k of a frame: bit index k/rep, index 0 is the start bit,
  // index b>0 carries word bit dw-b (MSB first).
  function automatic logic exp_chip(input logic [31:0] word, input int dw, input int rep, input int k);
    int b;
    b = k / rep;
    if (b == 0) return 1'b1;
    return word[dw-b];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] word);
    in_valid = 1'b1;
    in_data  = word;
    step();
    in_valid = 1'b0;
  endtask

  // Called in the first chip cycle; ends in the done cycle unless stop_at hits.
  task automatic run_frame(input logic [7:0] word, input int stall_at, input int stall_len,
                           input int stop_at);
    int n;
    n = chips_per_frame(8, 3);
    for (int k = 0; k < n; k++) begin
      if (k == stop_at) return;
      check("chip_valid", tx_valid, 1);
      check("chip_bit", tx_bit, exp_chip(word, 8, 3, k));
      check("chip_done", done, 0);
      check("chip_in_ready", in_ready, 0);
      if (k == 0) check("chip_busy", busy, 1);
      if (k == stall_at) begin
        tx_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          step();
          check("stall_valid", tx_valid, 1);
          check("stall_bit", tx_bit, exp_chip(word, 8, 3, k));
        end
        tx_ready = 1'b1;
      end
      step();
    end
    check("end_done", done, 1);
    check("end_in_ready", in_ready, 1);
    check("end_tx_valid", tx_valid, 0);
    check("end_tx_bit", tx_bit, 0);
    check("end_busy", busy, 0);
  endtask

  initial begin
    logic [7:0] word;
    logic [7:0] dec;
    logic       chips[$];
    int         cyc;
    int         ones;
    int         chip_err;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    tx_ready   = 1'b1;
    c_in_valid = 1'b0;
    c_in_data  = '0;
    c_tx_ready = 1'b1;

    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_bit", tx_bit, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_c_in_ready", c_in_ready, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_c_in_ready", c_in_ready, 1);
    check("post_rst_tx_valid", tx_valid, 0);

    // Nominal 0xA5 frame with back-to-back stalled repeat.
    accept(8'hA5);
    run_frame(8'hA5, -1, 0, -1);
    accept(8'hA5);
    run_frame(8'hA5, 9, 5, -1);

    // Word offered during a busy frame waits for the IDLE cycle.
    accept(8'hFF);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    run_frame(8'hFF, -1, 0, -1);
    step();
    in_valid = 1'b0;
    check("b2b_done_clear", done, 0);
    run_frame(8'h3C, -1, 0, -1);

    // Asynchronous reset at chip 12.
    accept(8'h5A);
    run_frame(8'h5A, -1, 0, 11);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", tx_valid, 0);
    check("mid_rst_tx_bit", tx_bit, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #3;
    check("mid_rst_hold_done", done, 0);
    rst_n = 1'b1;
    step();
    check("rel_in_ready", in_ready, 1);
    check("rel_done", done, 0);
    check("rel_tx_valid", tx_valid, 0);
    accept(8'h00);
    run_frame(8'h00, -1, 0, -1);

    // DATA_W=4, REPEAT=1 instance.
    c_in_valid = 1'b1;
    c_in_data  = 4'h9;
    step();
    c_in_valid = 1'b0;
    for (int k = 0; k < chips_per_frame(4, 1); k++) begin
      check("c_chip_valid", c_tx_valid, 1);
      check("c_chip_bit", c_tx_bit, exp_chip(32'h9, 4, 1, k));
      check("c_chip_done", c_done, 0);
      step();
    end
    check("c_done", c_done, 1);
    check("c_in_ready", c_in_ready, 1);
    check("c_tx_valid_end", c_tx_valid, 0);

    // Randomised loopback through a majority-vote receiver model.
    for (int f = 0; f < 25; f++) begin
      word = 8'($urandom);
      accept(word);
      chips.delete();
      cyc = 0;
      while (!done && cyc < 300) begin
        check("lb_valid", tx_valid, 1);
        tx_ready = ($urandom_range(0, 3) != 0);
        in_valid = 1'($urandom);
        in_data  = 8'($urandom);
        if (tx_valid && tx_ready) chips.push_back(tx_bit);
        step();
        cyc++;
      end
      tx_ready = 1'b1;
      in_valid = 1'b0;
      check("lb_timeout", (cyc < 300), 1);
      check("lb_chip_count", chips.size(), chips_per_frame(8, 3));
      chip_err = 0;
      for (int k = 0; k < chips.size() && k < chips_per_frame(8, 3); k++)
        if (chips[k] !== exp_chip(word, 8, 3, k)) chip_err++;
      check("lb_chip_errors", chip_err, 0);
      dec = '0;
      for (int b = 0; b < 9; b++) begin
        ones = 0;
        for (int r = 0; r < 3; r++)
          if (3 * b + r < chips.size() && chips[3*b+r] === 1'b1) ones++;
        if (b == 0) check("lb_start", (ones >= 2), 1);
        else        dec[8-b] = (ones >= 2);
      end
      check("lb_word", dec, word);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
